// File: rtl/usb_utmi_tx_if.sv
// SIE <-> UTMI transmit byte interface plus the FS line drive towards the transceiver.
// The master is the SIE side and the slave is the macrocell transmit path.
interface usb_utmi_tx_if;
  logic [1:0] op_mode;
  logic [7:0] data_in;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_dp;
  logic       tx_dn;
  logic       tx_oe;
  logic       tx_active;

  modport master (
    output op_mode, data_in, tx_valid,
    input  tx_ready, tx_dp, tx_dn, tx_oe, tx_active
  );

  modport slave (
    input  op_mode, data_in, tx_valid,
    output tx_ready, tx_dp, tx_dn, tx_oe, tx_active
  );
endinterface

// File: rtl/usb_utmi_tx.sv
// USB 2.0 full-speed UTMI transmit path: SYNC, LSB-first serialiser, bit stuffing,
// NRZI and EOP, driving registered D+/D-/OE towards the FS transceiver.
module usb_utmi_tx #(
  parameter int CLK_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  usb_utmi_tx_if.slave bus
);
  localparam int                CW       = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0]     BIT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [7:0]        SYNC_PAT = 8'h80;

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP_SE0, S_EOP_J} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] bit_cnt_reg, bit_cnt_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [2:0]    ones_reg, ones_next;
  logic [7:0]    shifter_reg, shifter_next;
  logic          raw_reg, raw_next;
  logic          dp_reg, dp_next;
  logic          dn_reg, dn_next;
  logic          oe_reg, oe_next;
  logic          active_reg, active_next;
  logic          ready_now;
  logic          send, send_bit;

  logic mode_normal, mode_raw, bit_end, stuff_due, byte_end;

  assign mode_normal = (bus.op_mode == 2'd0) || (bus.op_mode == 2'd3);
  assign mode_raw    = (bus.op_mode == 2'd2);
  assign bit_end     = (state_reg != S_IDLE) && (bit_cnt_reg == BIT_LAST);
  assign stuff_due   = !raw_reg && (ones_reg == 3'd6);
  // A pending stuff bit postpones the byte boundary by one bit time.
  assign byte_end    = bit_end && ((state_reg == S_SYNC) || (state_reg == S_DATA)) &&
                       (bit_idx_reg == 3'd7) && !stuff_due;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      bit_cnt_reg <= '0;
      bit_idx_reg <= '0;
      ones_reg    <= '0;
      shifter_reg <= '0;
      raw_reg     <= 1'b0;
      dp_reg      <= 1'b1;
      dn_reg      <= 1'b0;
      oe_reg      <= 1'b0;
      active_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      bit_idx_reg <= bit_idx_next;
      ones_reg    <= ones_next;
      shifter_reg <= shifter_next;
      raw_reg     <= raw_next;
      dp_reg      <= dp_next;
      dn_reg      <= dn_next;
      oe_reg      <= oe_next;
      active_reg  <= active_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.tx_valid && mode_normal)   state_next = S_SYNC;
        else if (bus.tx_valid && mode_raw) state_next = S_DATA;
      end
      S_SYNC, S_DATA: begin
        if (byte_end) begin
          if (bus.tx_valid)  state_next = S_DATA;
          else if (raw_reg)  state_next = S_IDLE;
          else               state_next = S_EOP_SE0;
        end
      end
      S_EOP_SE0: if (bit_end && bit_idx_reg[0]) state_next = S_EOP_J;
      S_EOP_J:   if (bit_end) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_next = (state_reg == S_IDLE || bit_end) ? '0 : bit_cnt_reg + CW'(1);
    bit_idx_next = bit_idx_reg;
    ones_next    = ones_reg;
    shifter_next = shifter_reg;
    raw_next     = raw_reg;
    dp_next      = dp_reg;
    dn_next      = dn_reg;
    oe_next      = oe_reg;
    active_next  = active_reg;
    ready_now    = 1'b0;
    send         = 1'b0;
    send_bit     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (bus.tx_valid && (mode_normal || mode_raw)) begin
          raw_next     = mode_raw;
          oe_next      = 1'b1;
          active_next  = 1'b1;
          bit_idx_next = 3'd0;
          send         = 1'b1;
          if (mode_raw) begin
            shifter_next = bus.data_in;
            ready_now    = 1'b1;
            send_bit     = bus.data_in[0];
          end else begin
            shifter_next = SYNC_PAT;
            send_bit     = SYNC_PAT[0];
          end
        end
      end
      S_SYNC, S_DATA: begin
        if (bit_end) begin
          if (stuff_due) begin
            dp_next   = ~dp_reg;
            dn_next   = ~dn_reg;
            ones_next = 3'd0;
          end else if (bit_idx_reg != 3'd7) begin
            bit_idx_next = bit_idx_reg + 3'd1;
            shifter_next = shifter_reg >> 1;
            send         = 1'b1;
            send_bit     = shifter_reg[1];
          end else if (bus.tx_valid) begin
            shifter_next = bus.data_in;
            ready_now    = 1'b1;
            bit_idx_next = 3'd0;
            send         = 1'b1;
            send_bit     = bus.data_in[0];
          end else if (raw_reg) begin
            oe_next     = 1'b0;
            active_next = 1'b0;
            dp_next     = 1'b1;
            dn_next     = 1'b0;
          end else begin
            dp_next      = 1'b0;
            dn_next      = 1'b0;
            bit_idx_next = 3'd0;
            ones_next    = 3'd0;
          end
        end
      end
      S_EOP_SE0: begin
        if (bit_end) begin
          if (bit_idx_reg[0]) begin
            dp_next = 1'b1;
            dn_next = 1'b0;
          end else begin
            bit_idx_next = 3'd1;
          end
        end
      end
      S_EOP_J: begin
        if (bit_end) begin
          oe_next      = 1'b0;
          active_next  = 1'b0;
          bit_idx_next = 3'd0;
        end
      end
      default: ;
    endcase

    // Raw mode maps the bit straight to J/K; otherwise NRZI with a ones run count.
    if (send) begin
      if (raw_next) begin
        dp_next = send_bit;
        dn_next = ~send_bit;
      end else if (send_bit) begin
        ones_next = ones_reg + 3'd1;
      end else begin
        dp_next   = ~dp_reg;
        dn_next   = ~dn_reg;
        ones_next = 3'd0;
      end
    end
  end

  assign bus.tx_ready  = ready_now;
  assign bus.tx_dp     = dp_reg;
  assign bus.tx_dn     = dn_reg;
  assign bus.tx_oe     = oe_reg;
  assign bus.tx_active = active_reg;
endmodule

// File: tb/tb_usb_utmi_tx.sv
// Directed bench for usb_utmi_tx: an SIE model feeds packets, a line-symbol scoreboard
// built from an independent NRZI/stuffing model is checked bit by bit.
module tb_usb_utmi_tx;
  localparam int CPB = 4;
  localparam logic [1:0] SYM_J = 2'b10, SYM_K = 2'b01, SYM_SE0 = 2'b00;

  logic clk = 1'b0;
  logic rst;
  usb_utmi_tx_if bus ();

  usb_utmi_tx #(.CLK_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] pkt [4];
  logic [1:0] sb_q [$];
  int         ready_t [$];

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] lvl_sym(input logic lvl);
    return lvl ? SYM_J : SYM_K;
  endfunction

  // Expected line symbols, one per bit time, for the packet held in pkt[0..n-1].
  task automatic model_packet(input logic [1:0] mode, input int n);
    logic       lvl;
    int         ones;
    logic [7:0] b;
    sb_q.delete();
    if (mode == 2'd1) return;
    if (mode == 2'd2) begin
      for (int i = 0; i < n; i++)
        for (int k = 0; k < 8; k++) sb_q.push_back(pkt[i][k] ? SYM_J : SYM_K);
      return;
    end
    lvl  = 1'b1;
    ones = 0;
    for (int i = -1; i < n; i++) begin
      b = (i < 0) ? 8'h80 : pkt[i];
      for (int k = 0; k < 8; k++) begin
        if (!b[k]) begin lvl = ~lvl; ones = 0; end
        else ones++;
        sb_q.push_back(lvl_sym(lvl));
        if (ones == 6) begin
          lvl  = ~lvl;
          ones = 0;
          sb_q.push_back(lvl_sym(lvl));
        end
      end
    end
    sb_q.push_back(SYM_SE0);
    sb_q.push_back(SYM_SE0);
    sb_q.push_back(SYM_J);
  endtask

  task automatic run_packet(input string name, input logic [1:0] mode, input int n,
                            input int linger, input int ncyc, input int exp_first);
    logic [1:0] obs_q [$];
    int   idx, post, oe_cnt, rises, act_bad, nexp, first;
    logic prev_oe, stable;
    logic [1:0] grp, e;
    model_packet(mode, n);
    nexp = sb_q.size();
    ready_t.delete();
    idx = 0; post = 0; oe_cnt = 0; rises = 0; act_bad = 0; prev_oe = 1'b0;
    bus.op_mode = mode;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      if (idx < n) begin bus.tx_valid = 1'b1; bus.data_in = pkt[idx]; end
      else if (post < linger) begin bus.tx_valid = 1'b1; post++; end
      else bus.tx_valid = 1'b0;
      @(negedge clk);
      if (bus.tx_ready === 1'b1) begin
        ready_t.push_back(c);
        if (idx < n) idx++;
      end
      if (bus.tx_oe === 1'b1) begin
        obs_q.push_back({bus.tx_dp, bus.tx_dn});
        oe_cnt++;
        if (!prev_oe) rises++;
      end
      if (bus.tx_active !== bus.tx_oe) act_bad++;
      prev_oe = (bus.tx_oe === 1'b1);
    end
    bus.tx_valid = 1'b0;
    first = (ready_t.size() > 0) ? ready_t[0] : -1;
    $display("[TB] %s: mode %0d, %0d bytes, tx_oe %0d clk, %0d tx_ready, first at %0d",
             name, mode, n, oe_cnt, ready_t.size(), first);
    chk({name, "/oe_len"}, oe_cnt, nexp * CPB);
    chk({name, "/oe_bursts"}, rises, (nexp > 0) ? 1 : 0);
    chk({name, "/ready_cnt"}, ready_t.size(), (mode == 2'd1) ? 0 : n);
    chk({name, "/ready_first"}, first, exp_first);
    chk({name, "/active_vs_oe"}, act_bad, 0);
    chk({name, "/end_line"}, {bus.tx_dp, bus.tx_dn, bus.tx_oe}, 3'b100);
    for (int b = 0; b < nexp; b++) begin
      e = sb_q.pop_front();
      if ((b + 1) * CPB <= obs_q.size()) begin
        grp    = obs_q[b * CPB];
        stable = 1'b1;
        for (int k = 1; k < CPB; k++)
          if (obs_q[b * CPB + k] !== grp) stable = 1'b0;
      end else begin
        grp    = 2'bxx;
        stable = 1'b0;
      end
      tests++;
      assert (stable && grp === e) else begin
        fails++;
        $error("FAIL %s/bit%0d: observed %b%s expected %b", name, b, grp,
               stable ? "" : " (unstable or missing)", e);
      end
    end
  endtask

  initial begin
    rst          = 1'b0;
    bus.op_mode  = 2'd0;
    bus.data_in  = 8'h00;
    bus.tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset/oe", bus.tx_oe, 0);
    chk("reset/line", {bus.tx_dp, bus.tx_dn}, SYM_J);
    chk("reset/active", bus.tx_active, 0);
    chk("reset/ready", bus.tx_ready, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    pkt[0] = 8'h00;
    run_packet("t1_byte00", 2'd0, 1, 0, 100, 8 * CPB);

    pkt[0] = 8'hFF;
    run_packet("t2_byteFF", 2'd0, 1, 0, 100, 8 * CPB);

    pkt[0] = 8'hC3; pkt[1] = 8'h3C; pkt[2] = 8'hA5;
    run_packet("t3_three", 2'd0, 3, 2, 180, 8 * CPB);
    if (ready_t.size() >= 3) begin
      chk("t3/gap1", ready_t[1] - ready_t[0], 8 * CPB);
      chk("t3/gap2", ready_t[2] - ready_t[1], 8 * CPB);
    end

    run_packet("t4_drop", 2'd0, 0, 1, 80, -1);

    run_packet("t5_nondrv", 2'd1, 0, 100, 110, -1);

    pkt[0] = 8'hF0;
    run_packet("t5_raw", 2'd2, 1, 0, 60, 0);

    // Reset in the middle of data bit 3 of an 0xFF packet.
    bus.op_mode = 2'd0;
    for (int c = 0; c <= 45; c++) begin
      @(posedge clk); #1;
      bus.tx_valid = 1'b1;
      bus.data_in  = 8'hFF;
      if (c == 45) rst = 1'b0;
      @(negedge clk);
      if (c == 44) chk("t6/pre_oe", bus.tx_oe, 1);
    end
    @(posedge clk); #1;
    rst          = 1'b1;
    bus.tx_valid = 1'b0;
    @(negedge clk);
    $display("[TB] t6_reset: mid-packet reset, tx_oe %0d tx_active %0d", bus.tx_oe, bus.tx_active);
    chk("t6/oe", bus.tx_oe, 0);
    chk("t6/line", {bus.tx_dp, bus.tx_dn}, SYM_J);
    chk("t6/active", bus.tx_active, 0);
    chk("t6/ready", bus.tx_ready, 0);
    repeat (3) @(posedge clk);

    pkt[0] = 8'hFF;
    run_packet("t6_after_rst", 2'd0, 1, 0, 100, 8 * CPB);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
